// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer: streams len operand chunks from memory
// through an external 4-lane Q8.8 dot unit and accumulates the sums.
module dot_seq_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [63:0]       rd_data_a,
    input  logic [63:0]       rd_data_b,
    output logic [63:0]       dp_a,
    output logic [63:0]       dp_b,
    input  logic [15:0]       dp_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic              valid_q;
    logic [15:0]       acc_q;
    logic [15:0]       res_q;
    logic              accept;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)              state_nx = IDLE;
                else if (rem_q == 'd1)  state_nx = DRAIN;
            end
            DRAIN: state_nx = abort ? IDLE : DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr = rd_en ? addr_q : '0;
    assign dp_a    = valid_q ? rd_data_a : '0;
    assign dp_b    = valid_q ? rd_data_b : '0;
    assign result  = res_q;

    // The last chunk lands in DRAIN, so result takes acc plus that sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            valid_q <= rd_en;
            if (accept) begin
                addr_q <= base_addr;
                rem_q  <= len;
            end else if (rd_en) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
            if (accept)       acc_q <= '0;
            else if (valid_q) acc_q <= acc_q + dp_out;
            if (accept && len == '0)
                res_q <= '0;
            else if (state == DRAIN && !abort)
                res_q <= acc_q + dp_out;
        end
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Scoreboard bench for dot_seq_ctrl with a behavioural memory
// and a behavioural 4-lane Q8.8 dot unit.
module tb_dot_seq_ctrl;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data_a = '0;
    logic [63:0]   rd_data_b = '0;
    logic [63:0]   dp_a;
    logic [63:0]   dp_b;
    logic [15:0]   dp_out;
    logic          busy;
    logic          done;
    logic [15:0]   result;

    logic [63:0]   mem_a [64];
    logic [63:0]   mem_b [64];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [AW-1:0] addr_q [$];
    logic [15:0]   res_q [$];
    int            due_q [$];
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [15:0]   last_res = '0;

    dot_seq_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_out    (dp_out),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    function automatic logic [15:0] lane_dot(input logic [63:0] a,
                                             input logic [63:0] b);
        logic [15:0] s;
        logic signed [31:0] p;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            p = signed'(a[16*i +: 16]) * signed'(b[16*i +: 16]);
            s = s + p[23:8];
        end
        return s;
    endfunction

    function automatic logic [15:0] exp_sum(input int b, input int n);
        logic [15:0] s;
        logic [AW-1:0] a;
        s = '0;
        for (int i = 0; i < n; i++) begin
            a = AW'(b + i);
            s = s + lane_dot(mem_a[a], mem_b[a]);
        end
        return s;
    endfunction

    assign dp_out = lane_dot(dp_a, dp_b);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            chk("dp_a", dp_a, prev_rd ? mem_a[prev_addr] : 64'h0);
            chk("dp_b", dp_b, prev_rd ? mem_b[prev_addr] : 64'h0);
            if (rd_en) begin
                if (addr_q.size() == 0) chk("rd_extra", rd_en, 0);
                else chk("rd_addr", rd_addr, addr_q.pop_front());
            end
            if (done) begin
                chk("done_busy", busy, 0);
                if (res_q.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    chk("result", result, res_q.pop_front());
                    chk("done_cycle", cyc, due_q.pop_front());
                end
            end
            prev_rd = rd_en;
            prev_addr = rd_addr;
        end
    end

    task automatic push_job(input int b, input int n, input logic [15:0] r);
        for (int i = 0; i < n; i++) addr_q.push_back(AW'(b + i));
        res_q.push_back(r);
        due_q.push_back(cyc + ((n == 0) ? 1 : n + 2));
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic run_job(input int b, input int n, input logic [15:0] r);
        @(negedge clk);
        base_addr = AW'(b);
        len = AW'(n);
        start = 1'b1;
        push_job(b, n, r);
        @(negedge clk);
        start = 1'b0;
        if (n != 0) chk("busy_run", busy, 1);
        else chk("done_len0", done, 1);
        wait_done(n + 8);
        last_res = r;
    endtask

    task automatic chk_zero();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
        chk("rst_result", result, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 64'h0100_0100_0100_0100;
            mem_b[i] = 64'h0200_0200_0200_0200;
        end
        #12;
        chk_zero();
        @(negedge clk);
        rst = 1'b0;

        run_job(0, 1, 16'h0800);
        run_job(62, 3, 16'h1800);
        run_job(0, 0, 16'h0000);
        run_job(0, 32, 16'h0000);
        run_job(0, 16, 16'h8000);

        for (int i = 40; i < 48; i++) begin
            mem_a[i] = {$urandom, $urandom};
            mem_b[i] = {$urandom, $urandom};
        end
        run_job(40, 8, exp_sum(40, 8));

        // start held high across a whole job and its DONE cycle
        @(negedge clk);
        base_addr = 6'd4;
        len = 6'd4;
        start = 1'b1;
        push_job(4, 4, 16'h2000);
        wait_done(20);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        base_addr = 6'd8;
        len = 6'd2;
        push_job(8, 2, 16'h1000);
        @(negedge clk);
        start = 1'b0;
        wait_done(12);
        last_res = 16'h1000;

        // abort in second RUN cycle
        @(negedge clk);
        base_addr = 6'd20;
        len = 6'd4;
        start = 1'b1;
        addr_q.push_back(6'd20);
        addr_q.push_back(6'd21);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        repeat (6) @(negedge clk);
        chk("abort_result", result, last_res);

        // asynchronous reset mid-RUN
        @(negedge clk);
        base_addr = 6'd30;
        len = 6'd8;
        start = 1'b1;
        addr_q.push_back(6'd30);
        addr_q.push_back(6'd31);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_run_rd_en", rd_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero();
        addr_q.delete();
        res_q.delete();
        due_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        run_job(30, 4, 16'h2000);
        repeat (3) @(negedge clk);
        chk("queues_empty", addr_q.size() + res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
